// File: rtl/multiword_add_ctrl.sv
// Purpose : serialises a W-bit add/subtract onto one external 4-bit adder slice,
//           one slice per clock, carry chained through a local register.
// Ports   : clk_i/rst_n_i (sync, active-low); start_i/sub_i/opa_i/opb_i request
//           (taken only while ready_o=1); add_a_o/add_b_o/add_cin_o drive the slice,
//           add_sum_i/add_cout_i return from it; valid_o/ack_i result handshake;
//           result_o/cout_o/ovf_o result, held until ack_i and retained in idle.
module multiword_add_ctrl #(
   parameter int NSLICE = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  start_i,
   input  logic                  sub_i,
   input  logic [4*NSLICE-1:0]   opa_i,
   input  logic [4*NSLICE-1:0]   opb_i,
   output logic                  ready_o,
   output logic [3:0]            add_a_o,
   output logic [3:0]            add_b_o,
   output logic                  add_cin_o,
   input  logic [3:0]            add_sum_i,
   input  logic                  add_cout_i,
   output logic                  valid_o,
   input  logic                  ack_i,
   output logic [4*NSLICE-1:0]   result_o,
   output logic                  cout_o,
   output logic                  ovf_o
);

   localparam int W  = 4 * NSLICE;
   localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [W-1:0]    opa_q;
   logic [W-1:0]    opb_q;      // already inverted for subtraction
   logic [W-1:0]    result_q;
   logic [W-1:0]    result_d;
   logic            carry_q;
   logic            cout_q;
   logic            ovf_q;
   logic            ovf_d;
   logic            ready_q;
   logic            valid_q;
   logic [IW-1:0]   idx_q;
   logic            idx_last;
   logic [3:0]      slice_a;
   logic [3:0]      slice_b;

   assign idx_last = (idx_q == IW'(NSLICE - 1));

   // Select the active slice and splice the adder's sum into the result image.
   always_comb begin
      slice_a  = 4'h0;
      slice_b  = 4'h0;
      result_d = result_q;
      for (int s = 0; s < NSLICE; s++) begin
         if (idx_q == IW'(s)) begin
            slice_a               = opa_q[4*s +: 4];
            slice_b               = opb_q[4*s +: 4];
            result_d[4*s +: 4]    = add_sum_i;
         end
      end
   end

   // Signed overflow: operands agree in sign but the top sum bit does not.
   assign ovf_d = (opa_q[W-1] == opb_q[W-1]) && (add_sum_i[3] != opa_q[W-1]);

   // Slice drive comes from registers only, so add_cout_i never reaches add_cin_o.
   assign add_a_o   = (state_q == RUN) ? slice_a : 4'h0;
   assign add_b_o   = (state_q == RUN) ? slice_b : 4'h0;
   assign add_cin_o = (state_q == RUN) ? carry_q : 1'b0;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         idx_q    <= '0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  opa_q    <= opa_i;
                  opb_q    <= sub_i ? ~opb_i : opb_i;
                  carry_q  <= sub_i;   // +1 completes the two's complement
                  idx_q    <= '0;
                  result_q <= '0;
                  cout_q   <= 1'b0;
                  ovf_q    <= 1'b0;
                  ready_q  <= 1'b0;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               result_q <= result_d;
               carry_q  <= add_cout_i;
               if (idx_last) begin
                  cout_q  <= add_cout_i;
                  ovf_q   <= ovf_d;
                  idx_q   <= '0;      // wrap instead of running past the top slice
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               if (ack_i) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ready_o  = ready_q;
   assign valid_o  = valid_q;
   assign result_o = result_q;
   assign cout_o   = cout_q;
   assign ovf_o    = ovf_q;

endmodule

// File: doc/multiword_add_ctrl.md
MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 Parameter NSLICE, default 4: number of 4-bit slices per operand; operand width W = 4*NSLICE.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst_n  input  1  reset, synchronous, active-low.
REQ-004 Start  input  1  request a new operation; accepted only when Ready=1.
REQ-005 Sub  input  1  0 = OpA+OpB, 1 = OpA-OpB; sampled with Start.
REQ-006 OpA, OpB  input  W  operands; sampled with Start.
REQ-007 Ready  output  1  controller idle and able to accept Start.
REQ-008 AddA, AddB  output  4  operand slice driven to the external 4-bit adder slice.
REQ-009 AddCin  output  1  carry-in driven to the external adder slice.
REQ-010 AddSum  input  4  combinational sum returned by the adder slice, same cycle.
REQ-011 AddCout  input  1  combinational carry-out returned by the adder slice, same cycle.
REQ-012 Valid  output  1  Result, Cout and Ovf are valid.
REQ-013 Ack  input  1  consumer accepts the result; meaningful only while Valid=1.
REQ-014 Result  output  W  sum or difference.
REQ-015 Cout  output  1  raw carry-out of the top slice (for Sub, 1 = no borrow).
REQ-016 Ovf  output  1  two's-complement signed overflow.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-018 IDLE: Ready=1; Start=1 at an edge SHALL capture OpA, B' = (Sub ? ~OpB : OpB), carry register = Sub, slice index = 0, clear Result/Cout/Ovf, and enter RUN.
REQ-019 Ready SHALL be 0 in RUN and DONE; Start in those states SHALL be ignored with no side effect.
REQ-020 RUN, slice index i: AddA = captured OpA[4i+3:4i], AddB = B'[4i+3:4i], AddCin = carry register.
REQ-021 Each RUN edge SHALL write AddSum into Result[4i+3:4i], load AddCout into the carry register, and increment i.
REQ-022 On the RUN edge with i = NSLICE-1, Cout SHALL take AddCout, Ovf SHALL be (OpA[W-1] == B'[W-1]) AND (AddSum[3] != OpA[W-1]), and the FSM SHALL enter DONE.
REQ-023 Latency: Valid SHALL rise exactly NSLICE edges after the edge that accepted Start (4 cycles at default).
REQ-024 Outside RUN, AddA, AddB and AddCin SHALL be driven 0.
REQ-025 DONE: Valid=1; Result, Cout and Ovf SHALL hold stable until Ack.
REQ-026 DONE with Ack=1 at an edge SHALL enter IDLE (Valid=0, Ready=1 next cycle); Start in that same cycle SHALL be ignored.
REQ-027 Result, Cout and Ovf SHALL retain their last values in IDLE until the next accepted Start.
REQ-028 Ack outside DONE SHALL be ignored.
REQ-029 Changes on OpA, OpB or Sub after acceptance SHALL NOT affect the operation in progress.
REQ-030 The slice index SHALL be ceil(log2(NSLICE)) bits wide and SHALL never exceed NSLICE-1.
REQ-031 Carry SHALL propagate only through the carry register between slices; there SHALL be no combinational path from AddCout to AddCin.

Reset
REQ-032 Rst_n=0 at an edge SHALL force IDLE, Ready=1, Valid=0, Result=0, Cout=0, Ovf=0, carry register=0, index=0, from any state including mid-RUN and DONE.
REQ-033 Reset SHALL take priority over Start and Ack in the same cycle.

Verification (NSLICE=4, bench models the adder slice)
REQ-034 0x1234 + 0x0FFF, Sub=0 -> Valid 4 edges after Start, Result=0x2233, Cout=0, Ovf=0.
REQ-035 0xFFFF + 0x0001 -> Result=0x0000, Cout=1, Ovf=0; AddCin=1 on slices 1, 2 and 3.
REQ-036 0x7FFF + 0x0001 -> Result=0x8000, Cout=0, Ovf=1; 0x0005 - 0x0007 (Sub=1) -> Result=0xFFFE, Cout=0, Ovf=0.
REQ-037 Start pulsed during RUN and during DONE, Ack held 0 for 3 cycles -> no restart, Result stable with Valid=1; Ack=1 -> Ready=1 next cycle.
REQ-038 Rst_n=0 while slice 2 is in RUN -> next cycle Ready=1, Valid=0, Result=0; a new Start then completes with a correct result.
